// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and parameter checks for the single-clock and future async FIFOs
package fifo_pkg;
  localparam int MIN_DEPTH = 2;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic bit params_ok(input int depth, input int af, input int ae);
    return depth >= MIN_DEPTH && af >= 1 && af <= depth && ae >= 0 && ae <= depth - 1;
  endfunction
endpackage

// File: rtl/fifo_sync_flags_if.sv
// fifo_sync_flags_if: producer/consumer handshake and status bundle for fifo_sync_flags
interface fifo_sync_flags_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = cnt_w(FIFO_DEPTH);
  logic                  cs;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output cs, wr_en, data_in, rd_en, clr_err,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  cs, wr_en, data_in, rd_en, clr_err,
    output data_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ptr_wrap.sv
// fifo_ptr_wrap: enabled FIFO pointer that wraps at FIFO_DEPTH-1, so any depth works
module fifo_ptr_wrap #(
  parameter int FIFO_DEPTH = 16,
  parameter int PW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [PW-1:0] ptr
);
  logic [PW-1:0] ptr_q, ptr_d;
  always_comb ptr_d = en ? ((ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : ptr_q + PW'(1)) : ptr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr = ptr_q;
endmodule

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with count, almost flags, read-valid and sticky error flags
// Define FIFO_SYNC_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle read.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4
) (
  input logic              clk,
  input logic              rst,
  fifo_sync_flags_if.slave bus
);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  if (!params_ok(FIFO_DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("fifo_sync_flags: illegal FIFO_DEPTH/AF_THRESH/AE_THRESH");
  end
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  full, empty, push_acc, pop_acc;
  // Acceptance looks only at the registered count, so a full FIFO rejects a push even alongside a pop.
  always_comb begin
    full        = count_q == CW'(FIFO_DEPTH);
    empty       = count_q == '0;
    push_acc    = bus.cs && bus.wr_en && !full;
    pop_acc     = bus.cs && bus.rd_en && !empty;
    count_d     = count_q + CW'(push_acc) - CW'(pop_acc);
    overflow_d  = (bus.cs && bus.wr_en && full) || (overflow_q && !bus.clr_err);
    underflow_d = (bus.cs && bus.rd_en && empty) || (underflow_q && !bus.clr_err);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  always_ff @(posedge clk)
    if (push_acc) mem_q[wr_ptr] <= bus.data_in;
  fifo_ptr_wrap #(.FIFO_DEPTH(FIFO_DEPTH), .PW(PW)) u_wr_ptr (.clk(clk), .rst(rst), .en(push_acc), .ptr(wr_ptr));
  fifo_ptr_wrap #(.FIFO_DEPTH(FIFO_DEPTH), .PW(PW)) u_rd_ptr (.clk(clk), .rst(rst), .en(pop_acc), .ptr(rd_ptr));
`ifdef FIFO_SYNC_FWFT_EN
  assign bus.data_out = mem_q[rd_ptr];
  assign bus.rd_valid = !empty;
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  always_comb begin
    data_out_d = pop_acc ? mem_q[rd_ptr] : data_out_q;
    rd_valid_d = pop_acc;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
`endif
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = count_q >= CW'(AF_THRESH);
  assign bus.almost_empty = count_q <= CW'(AE_THRESH);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: directed stimulus with a read-data scoreboard for depth-16 and depth-5 instances
module tb_fifo_sync_flags;
`ifdef FIFO_SYNC_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif
  logic clk, rst;
  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_a[$], exp_b[$];
  fifo_sync_flags_if #(.DATA_WIDTH(32), .FIFO_DEPTH(16)) ia ();
  fifo_sync_flags_if #(.DATA_WIDTH(32), .FIFO_DEPTH(5))  ib ();
  fifo_sync_flags #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .AF_THRESH(12), .AE_THRESH(4))
    u_a (.clk(clk), .rst(rst), .bus(ia));
  fifo_sync_flags #(.DATA_WIDTH(32), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(1))
    u_b (.clk(clk), .rst(rst), .bus(ib));
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic op_a(input logic c, input logic w, input logic [31:0] d, input logic r, input logic ce);
    ia.cs = c; ia.wr_en = w; ia.data_in = d; ia.rd_en = r; ia.clr_err = ce;
    @(posedge clk); #1;
  endtask

  task automatic op_b(input logic c, input logic w, input logic [31:0] d, input logic r, input logic ce);
    ib.cs = c; ib.wr_en = w; ib.data_in = d; ib.rd_en = r; ib.clr_err = ce;
    @(posedge clk); #1;
  endtask

  // Read-data monitors: a word is presented on rd_valid (registered mode) or taken by rd_en (fall-through).
  always @(negedge clk) begin
    if (FWFT ? (ia.cs && ia.rd_en && ia.rd_valid) : ia.rd_valid) begin
      if (exp_a.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_unexpected_read: got %h expected no read", ia.data_out);
      end else chk("a_read_data", ia.data_out, exp_a.pop_front());
    end
  end
  always @(negedge clk) begin
    if (FWFT ? (ib.cs && ib.rd_en && ib.rd_valid) : ib.rd_valid) begin
      if (exp_b.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_unexpected_read: got %h expected no read", ib.data_out);
      end else chk("b_read_data", ib.data_out, exp_b.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    ia.cs = 0; ia.wr_en = 0; ia.data_in = 0; ia.rd_en = 0; ia.clr_err = 0;
    ib.cs = 0; ib.wr_en = 0; ib.data_in = 0; ib.rd_en = 0; ib.clr_err = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(ia.count), 0);
    chk("rst_empty", 32'(ia.empty), 1);
    chk("rst_full", 32'(ia.full), 0);
    chk("rst_almost_empty", 32'(ia.almost_empty), 1);
    chk("rst_almost_full", 32'(ia.almost_full), 0);
    chk("rst_rd_valid", 32'(ia.rd_valid), 0);
    chk("rst_overflow", 32'(ia.overflow), 0);
    chk("rst_underflow", 32'(ia.underflow), 0);
    if (!FWFT) chk("rst_data_out", ia.data_out, 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      op_a(1, 1, 32'hA0 + 32'(i), 0, 0);
      chk("fill_count", 32'(ia.count), 32'(i + 1));
      chk("fill_almost_full", 32'(ia.almost_full), 32'(i + 1 >= 12));
      chk("fill_almost_empty", 32'(ia.almost_empty), 32'(i + 1 <= 4));
    end
    chk("fill_full", 32'(ia.full), 1);
    for (int i = 0; i < 16; i++) begin
      exp_a.push_back(32'hA0 + 32'(i));
      op_a(1, 0, 0, 1, 0);
      chk("drain_count", 32'(ia.count), 32'(15 - i));
    end
    op_a(1, 0, 0, 0, 0);
    chk("drain_empty", 32'(ia.empty), 1);
    chk("drain_full", 32'(ia.full), 0);
    chk("drain_rd_valid_low", 32'(ia.rd_valid), 0);

    for (int i = 0; i < 16; i++) op_a(1, 1, 32'hB0 + 32'(i), 0, 0);
    exp_a.push_back(32'hB0);
    op_a(1, 1, 32'hDEAD, 1, 0);
    chk("ovf_set", 32'(ia.overflow), 1);
    chk("ovf_count", 32'(ia.count), 15);
    chk("ovf_not_full", 32'(ia.full), 0);
    op_a(1, 1, 32'hC0, 0, 0);
    chk("refill_count", 32'(ia.count), 16);
    op_a(1, 1, 32'hEE, 0, 1);
    chk("ovf_set_wins_clear", 32'(ia.overflow), 1);
    chk("ovf_full_count", 32'(ia.count), 16);
    op_a(1, 0, 0, 0, 1);
    chk("ovf_cleared", 32'(ia.overflow), 0);
    for (int i = 0; i < 16; i++) begin
      exp_a.push_back(i < 15 ? 32'hB1 + 32'(i) : 32'hC0);
      op_a(1, 0, 0, 1, 0);
    end
    op_a(1, 0, 0, 0, 0);
    chk("ovf_drain_empty", 32'(ia.empty), 1);

    op_a(1, 1, 32'h55, 1, 0);
    chk("udf_set", 32'(ia.underflow), 1);
    chk("udf_count", 32'(ia.count), 1);
    chk("udf_no_overflow", 32'(ia.overflow), 0);
    for (int i = 0; i < 4; i++) begin
      op_a(0, 1, 32'h99, 1, 0);
      chk("cs_low_count", 32'(ia.count), 1);
      chk("cs_low_underflow", 32'(ia.underflow), 1);
      chk("cs_low_overflow", 32'(ia.overflow), 0);
    end
    exp_a.push_back(32'h55);
    op_a(1, 0, 0, 1, 0);
    op_a(1, 0, 0, 0, 0);
    chk("udf_pop_empty", 32'(ia.empty), 1);
    op_a(0, 0, 0, 0, 1);
    chk("cs_low_clr_err", 32'(ia.underflow), 0);
    op_a(0, 0, 0, 1, 0);
    chk("cs_low_no_udf_set", 32'(ia.underflow), 0);

    if (FWFT) begin
      op_a(1, 1, 32'h11, 0, 0);
      chk("fwft_data_out", ia.data_out, 32'h11);
      chk("fwft_rd_valid", 32'(ia.rd_valid), 1);
      exp_a.push_back(32'h11);
      op_a(1, 0, 0, 1, 0);
      chk("fwft_rd_valid_drop", 32'(ia.rd_valid), 0);
      chk("fwft_empty", 32'(ia.empty), 1);
    end

    op_a(1, 1, 32'h31, 0, 0);
    op_a(1, 1, 32'h32, 0, 0);
    exp_a.push_back(32'h31);
    op_a(1, 0, 0, 1, 0);
    @(negedge clk);
    ia.cs = 0; ia.rd_en = 0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_rd_valid", 32'(ia.rd_valid), 0);
    chk("midrst_count", 32'(ia.count), 0);
    chk("midrst_empty", 32'(ia.empty), 1);
    if (!FWFT) chk("midrst_data_out", ia.data_out, 0);
    @(negedge clk) rst = 1'b0;
    op_a(1, 0, 0, 0, 0);
    chk("postrst_count", 32'(ia.count), 0);
    chk("postrst_underflow", 32'(ia.underflow), 0);

    for (int i = 0; i < 3; i++) op_b(1, 1, 32'h10 + 32'(i), 0, 0);
    for (int i = 0; i < 13; i++) begin
      exp_b.push_back(32'h10 + 32'(i));
      op_b(1, 1, 32'h13 + 32'(i), 1, 0);
      chk("wrap_count", 32'(ib.count), 3);
    end
    for (int i = 0; i < 3; i++) begin
      exp_b.push_back(32'h1D + 32'(i));
      op_b(1, 0, 0, 1, 0);
    end
    op_b(1, 0, 0, 0, 0);
    chk("wrap_empty", 32'(ib.empty), 1);
    for (int i = 0; i < 5; i++) op_b(1, 1, 32'h40 + 32'(i), 0, 0);
    chk("d5_full", 32'(ib.full), 1);
    chk("d5_almost_full", 32'(ib.almost_full), 1);
    op_b(1, 1, 32'h45, 0, 0);
    chk("d5_count_capped", 32'(ib.count), 5);
    chk("d5_overflow", 32'(ib.overflow), 1);
    for (int i = 0; i < 5; i++) begin
      exp_b.push_back(32'h40 + 32'(i));
      op_b(1, 0, 0, 1, 0);
    end
    op_b(1, 0, 0, 0, 0);
    chk("d5_drain_empty", 32'(ib.empty), 1);

    repeat (2) @(posedge clk);
    #1;
    chk("a_scoreboard_drained", 32'(exp_a.size()), 0);
    chk("b_scoreboard_drained", 32'(exp_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
